// File: rtl/ni_inject_fifo.sv
// ni_inject_fifo: injection stage between a ROM flit source and a router port.
// On start, enables the source, captures PKT_LEN flits into a FIFO and
// forwards them over valid/ready with head/tail tagging.
// Ports:
//   clk, RST            clock (rising edge), asynchronous active-low reset
//   start               one-cycle request to inject one packet (IDLE only)
//   inj_enable          source enable, high only while filling
//   din, din_valid      flit stream from the source (no backpressure)
//   flit_out/valid      FIFO head, first-word fall-through; valid = non-empty
//   flit_ready          router accepts flit_out this cycle
//   flit_head/tail      first / last flit of the packet on flit_out
//   busy                packet in progress
//   done                last flit of the packet accepted (same cycle)
//   overflow            sticky: flit arrived when it could not be stored
module ni_inject_fifo #(
    parameter int unsigned DW      = 20,
    parameter int unsigned DEPTH   = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned PKT_LEN = 30
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          start,
    output logic          inj_enable,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic [DW-1:0] flit_out,
    output logic          flit_valid,
    input  logic          flit_ready,
    output logic          flit_head,
    output logic          flit_tail,
    output logic          busy,
    output logic          done,
    output logic          overflow
);

    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [CW-1:0] rx_cnt;
    logic [CW-1:0] tx_cnt;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          err;
    logic          rx_last;
    logic          tx_last;

    // Pointer compare: equal means empty, equal index with differing wrap bit means full
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = !empty && flit_ready;
    assign rx_last = (rx_cnt == CNT_LAST);
    assign tx_last = (tx_cnt == CNT_LAST);

    // Outputs decoded from registered state/pointers; done is combinational on accept
    assign inj_enable = (state == S_FILL);
    assign busy       = (state != S_IDLE);
    assign flit_valid = !empty;
    assign flit_out   = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign flit_head  = !empty && (tx_cnt == '0);
    assign flit_tail  = !empty && tx_last;
    assign done       = pop && tx_last;

    // Next-state, push and error decode
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        err       = 1'b0;
        case (state)
            S_IDLE: begin
                if (din_valid) err = 1'b1;
                if (start) state_nxt = S_FILL;
            end
            S_FILL: begin
                if (din_valid) begin
                    if (full) begin
                        err = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (rx_last) state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (din_valid) err = 1'b1;
                if (pop && tx_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, pointers, counters and sticky error
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_cnt   <= '0;
            tx_cnt   <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
                rx_cnt <= rx_last ? '0 : rx_cnt + CW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                tx_cnt <= tx_last ? '0 : tx_cnt + CW'(1);
            end
            if (err) overflow <= 1'b1;
        end
    end

    // Storage array, not reset; contents are only observed behind valid pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule
